// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: opcodes, ALU codes, select encodings and
// the multicycle controller state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_NOP = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } mc_state_t;

    // Immediate format implied by the opcode alone.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder shared by the single-cycle and multicycle controllers:
// maps ALUOp plus instruction fields to the ALU's 3-bit operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] i_ALUOp,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_ALUControl
);

    // ALUOp selects a fixed add/sub or a funct3-driven operation.
    always_comb begin
        o_ALUControl = ALU_ADD;
        case (i_ALUOp)
            ALUOP_ADD: o_ALUControl = ALU_ADD;
            ALUOP_SUB: o_ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type with funct7b5 subtracts; addi keeps add.
                    3'b000:  o_ALUControl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_ALUControl = ALU_SLT;
                    3'b110:  o_ALUControl = ALU_OR;
                    3'b111:  o_ALUControl = ALU_AND;
                    default: o_ALUControl = ALU_NOP;
                endcase
            end
            default: o_ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM main controller for the multicycle RISC-V datapath: sequences each
// instruction and drives every datapath enable and mux select.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_Zero,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ImmSrc,
    output logic [2:0] o_ALUControl
);

    mc_state_t  r_state;
    mc_state_t  w_next_state;
    logic       w_PCUpdate;
    logic       w_Branch;
    logic       w_MemWrite;
    logic       w_IRWrite;
    logic       w_RegWrite;
    logic [1:0] w_ALUOp;

    // State register; reset returns to FETCH from any state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state Moore outputs.
    always_comb begin
        w_next_state = S_FETCH;
        w_PCUpdate   = 1'b0;
        w_Branch     = 1'b0;
        w_MemWrite   = 1'b0;
        w_IRWrite    = 1'b0;
        w_RegWrite   = 1'b0;
        w_ALUOp      = ALUOP_ADD;
        o_AdrSrc     = 1'b0;
        o_ResultSrc  = RES_ALUOUT;
        o_ALUSrcA    = SRCA_PC;
        o_ALUSrcB    = SRCB_RS2;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
                w_IRWrite    = 1'b1;
                w_PCUpdate   = 1'b1;
                o_ALUSrcB    = SRCB_FOUR;
                o_ResultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                case (i_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                o_ALUSrcA    = SRCA_RS1;
                o_ALUSrcB    = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_next_state = S_MEMWB;
                o_AdrSrc     = 1'b1;
            end
            S_MEMWB: begin
                w_next_state = S_FETCH;
                o_ResultSrc  = RES_DATA;
                w_RegWrite   = 1'b1;
            end
            S_MEMWRITE: begin
                w_next_state = S_FETCH;
                o_AdrSrc     = 1'b1;
                w_MemWrite   = 1'b1;
            end
            S_EXECUTER: begin
                w_next_state = S_ALUWB;
                o_ALUSrcA    = SRCA_RS1;
                w_ALUOp      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                w_next_state = S_ALUWB;
                o_ALUSrcA    = SRCA_RS1;
                o_ALUSrcB    = SRCB_IMM;
                w_ALUOp      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_next_state = S_FETCH;
                w_RegWrite   = 1'b1;
            end
            S_JAL: begin
                w_next_state = S_ALUWB;
                o_ALUSrcA    = SRCA_OLDPC;
                o_ALUSrcB    = SRCB_FOUR;
                w_PCUpdate   = 1'b1;
            end
            S_BEQ: begin
                w_next_state = S_FETCH;
                o_ALUSrcA    = SRCA_RS1;
                w_ALUOp      = ALUOP_SUB;
                w_Branch     = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Write strobes are held off for as long as reset is asserted.
    assign o_PCWrite  = ~i_rst & (w_PCUpdate | (w_Branch & i_Zero));
    assign o_IRWrite  = ~i_rst & w_IRWrite;
    assign o_MemWrite = ~i_rst & w_MemWrite;
    assign o_RegWrite = ~i_rst & w_RegWrite;
    assign o_ImmSrc   = imm_src_of(i_op);

    alu_decoder u_alu_decoder (
        .i_ALUOp      (w_ALUOp),
        .i_funct3     (i_funct3),
        .i_op5        (i_op[5]),
        .i_funct7b5   (i_funct7b5),
        .o_ALUControl (o_ALUControl)
    );

endmodule
